// File: rtl/stream_packet_arbiter.sv
// Purpose : packet-atomic round-robin arbiter merging N_PORTS valid/ready streams into one.
// Latency : 1 cycle from first-beat request to grant, then zero-latency combinational pass-through.
// Backpr. : ready_tx is forwarded only to the granted port; requesters wait, IDLE strays are dropped.
// Option  : define ARB_WATCHDOG_EN to abort a packet stalled mid-flight for WDOG_CYCLES cycles.
module stream_packet_arbiter #(
  parameter int N_PORTS     = 4,
  parameter int DATA_W      = 32,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_PORTS-1:0]           valid_rx,
  output logic [N_PORTS-1:0]           ready_rx,
  input  logic [N_PORTS-1:0]           first_rx,
  input  logic [N_PORTS-1:0]           last_rx,
  input  logic [N_PORTS*DATA_W-1:0]    payload_rx,
  output logic                         valid_tx,
  input  logic                         ready_tx,
  output logic                         first_tx,
  output logic                         last_tx,
  output logic [DATA_W-1:0]            payload_tx,
  output logic                         busy,
  output logic [$clog2(N_PORTS)-1:0]   grant_idx,
  output logic                         wdog_err
);

  localparam int IDX_W = $clog2(N_PORTS);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PKT  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_grant_idx;
  logic [IDX_W-1:0]   w_grant_nxt;

  // Arbitration helpers
  logic [N_PORTS-1:0] w_req;
  logic [IDX_W-1:0]   w_scan;
  logic [IDX_W-1:0]   w_winner;
  logic               w_found;

  // Granted-port view
  logic [DATA_W-1:0]  w_pl [N_PORTS];
  logic               w_g_valid;
  logic               w_g_first;
  logic               w_g_last;
  logic [DATA_W-1:0]  w_g_payload;

  // Watchdog abort request (tied low when the watchdog is not built)
  logic               w_wdog_fire;

  // A port requests only when it presents the first beat of a packet.
  assign w_req = valid_rx & first_rx;

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_unpack
    assign w_pl[gi] = payload_rx[gi*DATA_W +: DATA_W];
  end

  assign w_g_valid   = valid_rx[r_grant_idx];
  assign w_g_first   = first_rx[r_grant_idx];
  assign w_g_last    = last_rx[r_grant_idx];
  assign w_g_payload = w_pl[r_grant_idx];

  // Round-robin search starting one past the last granted port, wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_grant_idx;
    w_scan   = r_grant_idx;
    for (int i = 0; i < N_PORTS; i++) begin
      if (w_scan == IDX_W'(N_PORTS - 1)) begin
        w_scan = '0;
      end else begin
        w_scan = w_scan + 1'b1;
      end
      if (!w_found && w_req[w_scan]) begin
        w_found  = 1'b1;
        w_winner = w_scan;
      end
    end
  end

  // Next-state and stream outputs; outputs are forced quiet while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant_idx;
    ready_rx    = '0;
    valid_tx    = 1'b0;
    first_tx    = 1'b0;
    last_tx     = 1'b0;
    payload_tx  = '0;
    case (r_state)
      S_IDLE: begin
        // Beats that are not packet starts are accepted and dropped to resync.
        ready_rx = valid_rx & ~first_rx;
        if (w_found) begin
          w_state_nxt = S_PKT;
          w_grant_nxt = w_winner;
        end
      end
      S_PKT: begin
        valid_tx   = w_g_valid;
        first_tx   = w_g_first;
        last_tx    = w_g_last;
        payload_tx = w_g_payload;
        ready_rx[r_grant_idx] = ready_tx;
        if (w_g_valid && ready_tx && w_g_last) begin
          w_state_nxt = S_IDLE;
        end else if (w_wdog_fire) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (!rst_n) begin
      ready_rx   = '0;
      valid_tx   = 1'b0;
      first_tx   = 1'b0;
      last_tx    = 1'b0;
      payload_tx = '0;
    end
  end

  // State and grant registers; reset points the pointer at the last port so port 0 wins first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_grant_idx <= IDX_W'(N_PORTS - 1);
    end else begin
      r_state     <= w_state_nxt;
      r_grant_idx <= w_grant_nxt;
    end
  end

  assign busy      = (r_state == S_PKT);
  assign grant_idx = r_grant_idx;

`ifdef ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(WDOG_CYCLES + 1);

  logic [CNT_W-1:0] r_wdog_cnt;
  logic [CNT_W-1:0] w_wdog_cnt_nxt;
  logic             r_wdog_err;

  // Count consecutive stalled cycles of the granted port; any valid beat restarts the count.
  always_comb begin
    w_wdog_cnt_nxt = '0;
    w_wdog_fire    = 1'b0;
    if (r_state == S_PKT && !w_g_valid) begin
      if (r_wdog_cnt == CNT_W'(WDOG_CYCLES - 1)) begin
        w_wdog_fire = 1'b1;
      end else begin
        w_wdog_cnt_nxt = r_wdog_cnt + 1'b1;
      end
    end
  end

  // Stall counter and sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wdog_cnt <= '0;
      r_wdog_err <= 1'b0;
    end else begin
      r_wdog_cnt <= w_wdog_cnt_nxt;
      if (w_wdog_fire) begin
        r_wdog_err <= 1'b1;
      end
    end
  end

  assign wdog_err = r_wdog_err;
`else
  logic w_unused_wdog;

  assign w_wdog_fire   = 1'b0;
  assign wdog_err      = 1'b0;
  assign w_unused_wdog = (WDOG_CYCLES > 0);
`endif

endmodule
